// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared op encodings for the pipelined barrel shifter
package shifter_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'd0,
        SHIFT_SRL = 2'd1,
        SHIFT_SRA = 2'd2,
        SHIFT_ROR = 2'd3
    } shift_op_t;

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one conditional 2^STAGE shift plus its enable-held pipeline register
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STAGE = 0,
    parameter int LOG2W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    input  shift_op_t        op,
    input  logic [LOG2W-1:0] amt,
    input  logic             ovr,
    input  logic             sign,
    output logic [WIDTH-1:0] shifted,
    input  logic [WIDTH-1:0] result,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q,
    output shift_op_t        op_q,
    output logic [LOG2W-1:0] amt_q,
    output logic             ovr_q,
    output logic             sign_q
);

    localparam int DIST = 1 << STAGE;

    // Shift by DIST when this stage's amount bit is set; SRA fills with the original sign
    always_comb begin
        shifted = data;
        if (amt[STAGE]) begin
            case (op)
                SHIFT_SLL: shifted = {data[WIDTH-1-DIST:0], {DIST{1'b0}}};
                SHIFT_SRL: shifted = {{DIST{1'b0}}, data[WIDTH-1:DIST]};
                SHIFT_SRA: shifted = {{DIST{sign}}, data[WIDTH-1:DIST]};
                SHIFT_ROR: shifted = {data[DIST-1:0], data[WIDTH-1:DIST]};
            endcase
        end
    end

    // Valid always advances when enabled; payload only loads for real ops so it holds across bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= SHIFT_SLL;
            amt_q   <= '0;
            ovr_q   <= 1'b0;
            sign_q  <= 1'b0;
        end else if (en) begin
            valid_q <= valid;
            if (valid) begin
                data_q <= result;
                op_q   <= op;
                amt_q  <= amt;
                ovr_q  <= ovr;
                sign_q <= sign;
            end
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// rtl/barrel_shifter_pipe.sv - log2(WIDTH)-stage pipelined barrel shifter with valid/ready handshake
module barrel_shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LOG2W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Z
);

    logic stall;

    // Element 0 is the accepted input; element k+1 is the register of stage k
    logic             valid_s [0:LOG2W];
    logic [WIDTH-1:0] data_s  [0:LOG2W];
    shift_op_t        op_s    [0:LOG2W];
    logic [LOG2W-1:0] amt_s   [0:LOG2W];
    logic             ovr_s   [0:LOG2W];
    logic             sign_s  [0:LOG2W];
    logic [WIDTH-1:0] shifted_s [0:LOG2W-1];
    logic [WIDTH-1:0] final_result;

    // A held result at the output freezes the whole pipe, bubbles included
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    assign valid_s[0] = in_valid;
    assign data_s[0]  = X;
    assign op_s[0]    = shift_op_t'(op);
    assign amt_s[0]   = Y[LOG2W-1:0];
    assign ovr_s[0]   = |Y[WIDTH-1:LOG2W];
    assign sign_s[0]  = X[WIDTH-1];

    for (genvar k = 0; k < LOG2W; k++) begin : g_stage
        if (k == LOG2W - 1) begin : g_last
            shift_stage #(.WIDTH(WIDTH), .STAGE(k), .LOG2W(LOG2W)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .en      (!stall),
                .valid   (valid_s[k]),
                .data    (data_s[k]),
                .op      (op_s[k]),
                .amt     (amt_s[k]),
                .ovr     (ovr_s[k]),
                .sign    (sign_s[k]),
                .shifted (shifted_s[k]),
                .result  (final_result),
                .valid_q (valid_s[k+1]),
                .data_q  (data_s[k+1]),
                .op_q    (op_s[k+1]),
                .amt_q   (amt_s[k+1]),
                .ovr_q   (ovr_s[k+1]),
                .sign_q  (sign_s[k+1])
            );
        end else begin : g_mid
            shift_stage #(.WIDTH(WIDTH), .STAGE(k), .LOG2W(LOG2W)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .en      (!stall),
                .valid   (valid_s[k]),
                .data    (data_s[k]),
                .op      (op_s[k]),
                .amt     (amt_s[k]),
                .ovr     (ovr_s[k]),
                .sign    (sign_s[k]),
                .shifted (shifted_s[k]),
                .result  (shifted_s[k]),
                .valid_q (valid_s[k+1]),
                .data_q  (data_s[k+1]),
                .op_q    (op_s[k+1]),
                .amt_q   (amt_s[k+1]),
                .ovr_q   (ovr_s[k+1]),
                .sign_q  (sign_s[k+1])
            );
        end
    end

    // Over-range saturation: logical shifts clear, SRA sign-fills, ROR keeps the modulo rotate
    always_comb begin
        final_result = shifted_s[LOG2W-1];
        if (ovr_s[LOG2W-1]) begin
            case (op_s[LOG2W-1])
                SHIFT_SLL: final_result = '0;
                SHIFT_SRL: final_result = '0;
                SHIFT_SRA: final_result = {WIDTH{sign_s[LOG2W-1]}};
                SHIFT_ROR: final_result = shifted_s[LOG2W-1];
            endcase
        end
    end

    assign out_valid = valid_s[LOG2W];
    assign Z         = data_s[LOG2W];

    // Sideband of the last register has no consumer
    logic unused_tail;
    assign unused_tail = ^{op_s[LOG2W], amt_s[LOG2W], ovr_s[LOG2W], sign_s[LOG2W]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb/tb_barrel_shifter_pipe.sv - scoreboard bench for barrel_shifter_pipe at WIDTH 32, 8 and 64
module tb_barrel_shifter_pipe;

    typedef struct {
        logic [63:0] z;
        int          acc;
        int          st;
    } exp_t;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [1:0]  op;
        logic [31:0] z;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [63:0] x_a [3];
    logic [63:0] y_a [3];
    logic [1:0]  op_a [3];
    logic        iv_a [3];
    logic        ordy_a [3];

    logic        ir0, ir1, ir2, ov0, ov1, ov2;
    logic [31:0] z0;
    logic [7:0]  z1;
    logic [63:0] z2;
    logic [63:0] z_a [3];
    logic        ir_a [3];
    logic        ov_a [3];

    always_comb begin
        z_a[0]  = {32'd0, z0};
        z_a[1]  = {56'd0, z1};
        z_a[2]  = z2;
        ir_a[0] = ir0;
        ir_a[1] = ir1;
        ir_a[2] = ir2;
        ov_a[0] = ov0;
        ov_a[1] = ov1;
        ov_a[2] = ov2;
    end

    barrel_shifter_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv_a[0]), .in_ready(ir0),
        .X(x_a[0][31:0]), .Y(y_a[0][31:0]), .op(op_a[0]),
        .out_valid(ov0), .out_ready(ordy_a[0]), .Z(z0)
    );

    barrel_shifter_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv_a[1]), .in_ready(ir1),
        .X(x_a[1][7:0]), .Y(y_a[1][7:0]), .op(op_a[1]),
        .out_valid(ov1), .out_ready(ordy_a[1]), .Z(z1)
    );

    barrel_shifter_pipe #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(iv_a[2]), .in_ready(ir2),
        .X(x_a[2]), .Y(y_a[2]), .op(op_a[2]),
        .out_valid(ov2), .out_ready(ordy_a[2]), .Z(z2)
    );

    int          widths [3] = '{32, 8, 64};
    int          lats   [3] = '{5, 3, 6};
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          stalls [3];
    logic        prev_stall [3];
    logic [63:0] held_z [3];
    logic        acc [3];
    exp_t        pend [3];
    exp_t        q0 [$];
    exp_t        q1 [$];
    exp_t        q2 [$];

    task automatic chk(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (w%0d) at cycle %0d: got %h, expected %h", name, widths[g], cyc, act, exp);
        end
    endtask

    function automatic int qsize(input int g);
        case (g)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpush(input int g, input exp_t e);
        case (g)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic qpop(input int g, output exp_t e);
        case (g)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] ref_shift(input logic [63:0] xi, input logic [63:0] yi,
                                              input logic [1:0] o, input int w);
        logic [63:0] m, x, y, r;
        logic        s, big;
        int          a;
        m   = wmask(w);
        x   = xi & m;
        y   = yi & m;
        s   = x[w-1];
        big = (y >= 64'(w));
        a   = int'(y % 64'(w));
        case (o)
            2'd0: r = big ? 64'd0 : (x << a);
            2'd1: r = big ? 64'd0 : (x >> a);
            2'd2: r = big ? (s ? m : 64'd0) : ((x >> a) | (s ? (m & ~(m >> a)) : 64'd0));
            default: r = (a == 0) ? x : ((x >> a) | (x << (w - a)));
        endcase
        return r & m;
    endfunction

    task automatic mon(input int g);
        exp_t e;
        if (ov_a[g] && ordy_a[g]) begin
            if (qsize(g) == 0) begin
                chk("unexpected_output_valid", g, 64'(ov_a[g]), 64'd0);
            end else begin
                qpop(g, e);
                chk("z", g, z_a[g], e.z);
                chk("latency", g, 64'(cyc - e.acc), 64'(lats[g] + stalls[g] - e.st));
            end
        end
        if (prev_stall[g]) begin
            chk("stall_hold_z", g, z_a[g], held_z[g]);
            chk("stall_hold_valid", g, 64'(ov_a[g]), 64'd1);
        end
        if (ov_a[g] && !ordy_a[g]) begin
            stalls[g]++;
            prev_stall[g] = 1'b1;
            held_z[g]     = z_a[g];
        end else begin
            prev_stall[g] = 1'b0;
        end
        acc[g] = 1'b0;
        if (iv_a[g] && ir_a[g]) begin
            acc[g] = 1'b1;
            e      = pend[g];
            e.acc  = cyc;
            e.st   = stalls[g];
            qpush(g, e);
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int g = 0; g < 3; g++) mon(g);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain(input int g);
        int n;
        n = 0;
        while (qsize(g) != 0 && n < 60) begin
            step();
            n++;
        end
        chk("drain_queue_empty", g, 64'(qsize(g)), 64'd0);
    endtask

    task automatic drive_one(input vec_t v);
        int n;
        x_a[0]    = {32'd0, v.x};
        y_a[0]    = {32'd0, v.y};
        op_a[0]   = v.op;
        iv_a[0]   = 1'b1;
        pend[0].z = {32'd0, v.z};
        n = 0;
        do begin
            step();
            n++;
        end while (!acc[0] && n < 20);
        chk("accept", 0, 64'(acc[0]), 64'd1);
        iv_a[0] = 1'b0;
        drain(0);
    endtask

    vec_t vt [19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        int idx, t;
        vec_t v;
        logic [63:0] m;

        vt[0]  = '{32'h8000_0000, 32'd4,          2'd1, 32'h0800_0000};
        vt[1]  = '{32'h0000_0001, 32'd31,         2'd0, 32'h8000_0000};
        vt[2]  = '{32'hF000_0000, 32'd4,          2'd2, 32'hFF00_0000};
        vt[3]  = '{32'h7000_0000, 32'd4,          2'd2, 32'h0700_0000};
        vt[4]  = '{32'hDEAD_BEEF, 32'd32,         2'd1, 32'h0000_0000};
        vt[5]  = '{32'hDEAD_BEEF, 32'h8000_0000,  2'd0, 32'h0000_0000};
        vt[6]  = '{32'hDEAD_BEEF, 32'd40,         2'd2, 32'hFFFF_FFFF};
        vt[7]  = '{32'hDEAD_BEEF, 32'd36,         2'd3, 32'hFDEA_DBEE};
        vt[8]  = '{32'hDEAD_BEEF, 32'd0,          2'd0, 32'hDEAD_BEEF};
        vt[9]  = '{32'hDEAD_BEEF, 32'd0,          2'd1, 32'hDEAD_BEEF};
        vt[10] = '{32'hDEAD_BEEF, 32'd0,          2'd2, 32'hDEAD_BEEF};
        vt[11] = '{32'hDEAD_BEEF, 32'd0,          2'd3, 32'hDEAD_BEEF};
        vt[12] = '{32'h8000_0000, 32'd31,         2'd2, 32'hFFFF_FFFF};
        vt[13] = '{32'h1234_5678, 32'hFFFF_FFFF,  2'd3, 32'h2468_ACF0};
        vt[14] = '{32'h1234_5678, 32'd31,         2'd1, 32'h0000_0000};
        vt[15] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF,  2'd2, 32'h0000_0000};
        vt[16] = '{32'h0000_0001, 32'd1,          2'd3, 32'h8000_0000};
        vt[17] = '{32'hDEAD_BEEF, 32'd32,         2'd3, 32'hDEAD_BEEF};
        vt[18] = '{32'h1234_5678, 32'd4,          2'd0, 32'h2345_6780};

        for (int g = 0; g < 3; g++) begin
            x_a[g]        = '0;
            y_a[g]        = '0;
            op_a[g]       = 2'd0;
            iv_a[g]       = 1'b0;
            ordy_a[g]     = 1'b1;
            stalls[g]     = 0;
            prev_stall[g] = 1'b0;
            held_z[g]     = '0;
            acc[g]        = 1'b0;
            pend[g]       = '{64'd0, 0, 0};
        end
        rst = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("reset_out_valid", g, 64'(ov_a[g]), 64'd0);
            chk("reset_z", g, z_a[g], 64'd0);
            chk("reset_in_ready", g, 64'(ir_a[g]), 64'd1);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        for (int i = 0; i < 19; i++) drive_one(vt[i]);

        idx = 0;
        t   = 0;
        while (idx < 10 && t < 60) begin
            x_a[0]    = 64'h0000_0000_FFFF_FFFF;
            y_a[0]    = 64'(idx);
            op_a[0]   = 2'd1;
            iv_a[0]   = 1'b1;
            pend[0].z = 64'h0000_0000_FFFF_FFFF >> idx;
            ordy_a[0] = !(t >= 7 && t <= 9);
            step();
            if (acc[0]) idx++;
            t++;
        end
        chk("stream_all_accepted", 0, 64'(idx), 64'd10);
        chk("stream_stall_seen", 0, 64'(stalls[0] >= 3), 64'd1);
        iv_a[0]   = 1'b0;
        ordy_a[0] = 1'b1;
        drain(0);

        ordy_a[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            x_a[0]    = 64'h0000_0000_FFFF_FFFF;
            y_a[0]    = 64'(i + 1);
            op_a[0]   = 2'd1;
            iv_a[0]   = 1'b1;
            pend[0].z = 64'h0000_0000_FFFF_FFFF >> (i + 1);
            step();
        end
        iv_a[0] = 1'b0;
        step();
        step();
        chk("pre_reset_out_valid", 0, 64'(ov0), 64'd1);
        chk("pre_reset_z", 0, 64'(z0), 64'h7FFF_FFFF);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_out_valid", 0, 64'(ov0), 64'd0);
        chk("async_reset_z", 0, 64'(z0), 64'd0);
        chk("async_reset_in_ready", 0, 64'(ir0), 64'd1);
        q0.delete();
        prev_stall[0] = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        ordy_a[0] = 1'b1;
        repeat (10) step();
        chk("no_stale_after_reset", 0, 64'(ov0), 64'd0);
        v = '{32'h0000_0001, 32'd31, 2'd0, 32'h8000_0000};
        drive_one(v);

        for (t = 0; t < 200; t++) begin
            for (int g = 0; g < 3; g++) begin
                if (!iv_a[g] || acc[g]) begin
                    m       = wmask(widths[g]);
                    iv_a[g] = ($urandom_range(0, 4) != 0) && (t < 190);
                    x_a[g]  = {$urandom, $urandom} & m;
                    case ($urandom_range(0, 3))
                        0, 3: y_a[g] = 64'($urandom_range(0, widths[g] - 1));
                        1:    y_a[g] = 64'($urandom_range(widths[g], 2 * widths[g]));
                        default: y_a[g] = {$urandom, $urandom} & m;
                    endcase
                    op_a[g]   = 2'($urandom_range(0, 3));
                    pend[g].z = ref_shift(x_a[g], y_a[g], op_a[g], widths[g]);
                end
                ordy_a[g] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        for (int g = 0; g < 3; g++) begin
            iv_a[g]   = 1'b0;
            ordy_a[g] = 1'b1;
        end
        for (int g = 0; g < 3; g++) drain(g);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Parametrised, pipelined barrel shifter for the ALU datapath: logical left, logical right, arithmetic right and rotate right on a WIDTH-bit operand. One registered shift stage per amount bit, so latency is log2(WIDTH) cycles and throughput is one operation per cycle. A valid/ready handshake on both sides lets it sit between the operand-fetch and writeback stages of the multi-cycle ALU. Over-range shift amounts saturate cleanly: 0 for logical shifts, sign fill for SRA, modulo WIDTH for rotate.

## Interface
Parameters:
- WIDTH, 32: operand width; power of two, 8..64.
- LOG2W, $clog2(WIDTH): number of shift stages, which equals latency; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  X/Y/op valid.
- in_ready  out  1  block accepts the operation this cycle.
- X  in  WIDTH  operand to shift.
- Y  in  WIDTH  shift amount; full width, unsigned.
- op  in  2  operation select: SLL=0, SRL=1, SRA=2, ROR=3.
- out_valid  out  1  Z holds a result.
- out_ready  in  1  downstream accepts Z.
- Z  out  WIDTH  result.

## Operation
- Accept: an input transfer occurs when in_valid && in_ready. X, op, Y[LOG2W-1:0] and an overrange flag (OR of Y[WIDTH-1:LOG2W]) enter stage 0.
- Stage k (0..LOG2W-1):
  - Shifts its data by 2^k when amount bit k is 1.
  - Fill bits: 0 for SLL/SRL; data MSB as captured at input (sign bit of original X) for SRA; wrapped bits for ROR.
  - Each stage carries valid, op, amount, overrange and sign alongside the data.
- Final stage, when overrange is 1:
  - SLL/SRL replace the result with 0.
  - SRA replaces it with {WIDTH{sign}}.
  - ROR ignores overrange; the result is a rotate by Y mod WIDTH.
- Y interpretation: Y is always unsigned. A Y value with the MSB set is an over-range shift, never a negative one.
- Stall: stall = out_valid && !out_ready.
  - While stall is 1, every stage register, including Z and out_valid, holds its value.
  - in_ready = !stall.
- Bubbles: bubbles are not compressed. A stage whose valid is 0 still advances when there is no stall.
- Z holds its last value while out_valid is 0. It is never X-propagated.

## Timing
- Reset: out_valid=0, Z=0, all stage valids=0, in_ready=1 (combinational from out_valid). Reset mid-operation discards all in-flight operations; none are emitted after reset is released.
- Latency: an operation accepted at edge n appears with out_valid=1 after edge n+LOG2W, i.e. 5 cycles for WIDTH=32. This assumes no stall.
- Latency under backpressure: each stalled cycle adds exactly one cycle.
- Throughput: one accept per cycle while out_ready=1.
- Handshake rules:
  - Z and out_valid stay stable from assertion until the out_ready handshake.
  - in_ready has no combinational dependency on in_valid.
  - in_ready depends combinationally on out_ready.
- Simultaneous events: when out_valid && out_ready && in_valid hold in the same cycle, the pipe advances, the head is consumed and the new input is accepted in that one cycle.
- Boundaries:
  - Y=0 returns X unchanged for every op.
  - Y=WIDTH-1 is in range.
  - Y=WIDTH is over-range.
  - Y=2^WIDTH-1 is over-range.

## Structure
- Package shifter_pkg holds:
  - the op encodings SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROR;
  - a typedef for the 2-bit op.
- Sub-module shift_stage is parametrised by WIDTH and STAGE (shift distance 2^STAGE). It contains:
  - the combinational shift/fill for its stage;
  - its enable-held register (data, op, amount, overrange, sign, valid).
- barrel_shifter_pipe:
  - generates LOG2W shift_stage instances;
  - computes overrange and the stall logic;
  - applies the over-range override before the last stage's register.

## Test plan
- Reset then single ops, WIDTH=32, out_ready=1:
  - SRL X=0x80000000, Y=4 -> Z=0x08000000 after exactly 5 cycles;
  - SLL X=0x1, Y=31 -> Z=0x80000000.
- SRA sign fill:
  - X=0xF0000000, Y=4 -> Z=0xFF000000;
  - X=0x70000000, Y=4 -> Z=0x07000000.
- Over-range, X=0xDEADBEEF:
  - Y=32 with SRL -> 0x00000000;
  - Y=0x80000000 with SLL -> 0x00000000;
  - Y=40 with SRA -> 0xFFFFFFFF;
  - Y=36 with ROR -> 0xFDEADBEE (rotate by 4).
- Streaming plus backpressure:
  - Drive 10 back-to-back SRL ops with Y=0..9 and X=0xFFFFFFFF.
  - Deassert out_ready for 3 cycles mid-stream.
  - Required: all 10 results arrive in order with no loss or duplication, and Z stays stable during the stall.
- Reset mid-stream:
  - Assert rst with 3 operations in flight.
  - Required: out_valid=0 and Z=0 immediately (asynchronously); no stale result appears after release.
  - A fresh op after release returns after 5 cycles.
- Parameter sweep, WIDTH=8 and 64:
  - Random X/Y/op checked against a reference model.
  - Required: latency equals 3 and 6 cycles respectively.
